// File: rtl/aurora_tx_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aurora_tx_sched : frame-atomic two-source scheduler for the Aurora TX port
// Rev 1.0
// ---------------------------------------------------------------------------
module aurora_tx_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int GAP_WIDTH  = 16
) (
  input  logic                    aclk,
  input  logic                    reset,
  input  logic                    channel_up,
  input  logic [GAP_WIDTH-1:0]    cfg_gap,
  input  logic                    cfg_rr,
  input  logic [DATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic                    s0_axis_tvalid,
  input  logic                    s0_axis_tlast,
  output logic                    s0_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic                    s1_axis_tvalid,
  input  logic                    s1_axis_tlast,
  output logic                    s1_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [1:0]              grant,
  output logic [15:0]             frame_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             grant_q, grant_d;
  logic                   last_grant_q, last_grant_d;  // index of most recent grant
  logic [15:0]            frame_count_q, frame_count_d;
  logic [GAP_WIDTH-1:0]   gap_q, gap_d;

  logic                   pick1;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_valid;
  logic                   out_last;
  logic                   rdy0;
  logic                   rdy1;

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= 2'b00;
      last_grant_q  <= 1'b1;
      frame_count_q <= 16'd0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      frame_count_q <= frame_count_d;
      gap_q         <= gap_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    frame_count_d = frame_count_q;
    gap_d         = gap_q;
    pick1         = 1'b0;
    out_data      = '0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    rdy0          = 1'b0;
    rdy1          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (channel_up && (s0_axis_tvalid || s1_axis_tvalid)) begin
          if (s0_axis_tvalid && s1_axis_tvalid) begin
            pick1 = cfg_rr ? ~last_grant_q : 1'b0;
          end else begin
            pick1 = s1_axis_tvalid;
          end
          grant_d      = pick1 ? 2'b10 : 2'b01;
          last_grant_d = pick1;
          state_d      = ST_XFER;
        end
      end

      ST_XFER: begin
        // Pure pass-through; backpressure goes straight to the granted source.
        if (grant_q[1]) begin
          out_data  = s1_axis_tdata;
          out_valid = s1_axis_tvalid;
          out_last  = s1_axis_tlast;
          rdy1      = m_axis_tready;
        end else begin
          out_data  = s0_axis_tdata;
          out_valid = s0_axis_tvalid;
          out_last  = s0_axis_tlast;
          rdy0      = m_axis_tready;
        end
        if (out_valid && m_axis_tready && out_last) begin
          frame_count_d = frame_count_q + 16'd1;
          gap_d         = cfg_gap;
          grant_d       = 2'b00;
          state_d       = (cfg_gap != '0) ? ST_GAP : ST_IDLE;
        end
      end

      ST_GAP: begin
        gap_d = gap_q - GAP_WIDTH'(1);
        if (gap_q == GAP_WIDTH'(1)) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  assign m_axis_tdata   = out_data;
  assign m_axis_tvalid  = out_valid;
  assign m_axis_tlast   = out_last;
  assign m_axis_tkeep   = '1;
  assign s0_axis_tready = rdy0;
  assign s1_axis_tready = rdy1;
  assign grant          = grant_q;
  assign frame_count    = frame_count_q;

endmodule
`default_nettype wire

// File: doc/aurora_tx_sched.md
# aurora_tx_sched

Frame-atomic transmit scheduler in front of the Aurora 8b10b TX AXI-Stream port, in the `user_clk_out` domain. It shares the single Aurora TX channel between two frame sources: input 0 is the RX loopback FIFO and input 1 is the host/VILLAS register path. A whole frame from one source is passed through before the other source is granted. A programmable inter-frame gap is inserted after every frame, which provides the configurable RTDS packet delay.

## Interface
Parameters:
- `DATA_WIDTH`, 32: stream data width; must be a multiple of 8.
- `GAP_WIDTH`, 16: width of the gap configuration and the gap counter.

Ports:
- `aclk`  in  1  Aurora user clock (`user_clk_out`).
- `reset`  in  1  synchronous, active-high reset (driven from `sys_reset_out`).
- `channel_up`  in  1  Aurora channel status; new grants are issued only while this is high.
- `cfg_gap`  in  GAP_WIDTH  idle cycles inserted after each frame.
- `cfg_rr`  in  1  arbitration mode: 1 = round-robin, 0 = fixed priority with input 0 winning.
- `s0_axis_tdata`  in  DATA_WIDTH  input 0 data (loopback FIFO).
- `s0_axis_tvalid`  in  1  input 0 valid.
- `s0_axis_tlast`  in  1  input 0 last beat of frame.
- `s0_axis_tready`  out  1  input 0 ready.
- `s1_axis_tdata`, `s1_axis_tvalid`, `s1_axis_tlast`, `s1_axis_tready`: same as input 0, for input 1 (host path).
- `m_axis_tdata`  out  DATA_WIDTH  data to Aurora `s_axi_tx_tdata`.
- `m_axis_tkeep`  out  DATA_WIDTH/8  always all-ones.
- `m_axis_tvalid`  out  1  valid to Aurora.
- `m_axis_tlast`  out  1  last beat to Aurora.
- `m_axis_tready`  in  1  `s_axi_tx_tready` from Aurora.
- `grant`  out  2  one-hot active source; 2'b00 when no frame is in flight.
- `frame_count`  out  16  count of completed frames; wraps.

## Operation
The scheduler is a three-state FSM: IDLE, XFER, GAP.

IDLE:
- If `channel_up`=1 and any `sN_axis_tvalid`=1, register `grant` and go to XFER.
- Only one input requesting: grant that input.
- Both requesting with `cfg_rr`=0: grant input 0.
- Both requesting with `cfg_rr`=1: grant the input not in `last_grant`.
- `last_grant` updates whenever a grant is issued. Its reset value is 1, so input 0 wins the first tie.
- If `channel_up`=0, stay in IDLE regardless of valids.

XFER (combinational pass-through of the granted input):
- `m_axis_tdata`/`tvalid`/`tlast` follow the granted input.
- The granted `sN_axis_tready` = `m_axis_tready`.
- The non-granted input's `tready` = 0.
- On a handshake beat (`m_axis_tvalid` & `m_axis_tready`) with `m_axis_tlast`=1:
  - increment `frame_count`;
  - latch `cfg_gap` into the gap counter;
  - go to GAP if the latched value is non-zero, otherwise go to IDLE.
- `grant` returns to 00 in the cycle after the last beat.

GAP:
- Down-counter decrements every cycle.
- Go to IDLE when it reaches 1; total time in GAP is exactly `cfg_gap` cycles.
- Both input `tready` = 0 and `m_axis_tvalid` = 0.

Boundary rules:
- `channel_up` falling mid-frame does not abort the frame. Flow is governed by `m_axis_tready`, and the frame completes when Aurora resumes.
- Single-beat frames (`tvalid` & `tlast` on the first beat) are legal and count as one frame.
- Changes to `cfg_gap` or `cfg_rr` during XFER/GAP take effect only at the next sampling point: the tlast handshake for `cfg_gap`, the next IDLE decision for `cfg_rr`.
- `frame_count` wraps from 16'hFFFF to 0.
- Valid input that drops without a handshake is an upstream AXI protocol violation. It is not handled beyond pass-through.

## Timing
Reset values:
- State IDLE, `grant`=00, `last_grant`=1, `frame_count`=0, gap counter=0.
- `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0.
- `s0_axis_tready`=0, `s1_axis_tready`=0.
- `m_axis_tkeep` = all-ones at all times.

Latencies:
- Arbitration: valid seen in IDLE at cycle t gives the first `m_axis_tvalid` at t+1.
- Data path in XFER: 0 cycles (combinational). There is no skid buffer, and no beats are held internally.
- After a tlast handshake at cycle t, the earliest next `m_axis_tvalid` is t+`cfg_gap`+2.

Reset mid-frame:
- All outputs return to their reset values in the cycle after `reset` is sampled high.
- The partial frame is truncated and is not counted.

## Test plan
- Input 0 only: 4-beat frame 0x10..0x13, `cfg_gap`=0, tready=1 → m beats 0x10..0x13 on cycles t+1..t+4, tlast on 0x13, `frame_count`=1, `grant`=01 then 00.
- Both inputs hold 2-beat frames continuously, `cfg_rr`=1 → output frame order 0,1,0,1; `frame_count`=4 after four frames. With `cfg_rr`=0 → only input 0 is served.
- `cfg_gap`=5, back-to-back frames on input 1 → exactly 6 cycles with `m_axis_tvalid`=0 between a tlast handshake and the next first beat.
- `m_axis_tready` toggles 1,0,0,1 during a 3-beat frame, and `channel_up` drops mid-frame → all 3 beats are delivered in order with none duplicated. After the frame, no new grant is issued until `channel_up`=1.
- `reset` asserted on beat 2 of a 4-beat frame → next cycle all outputs are at reset values and `frame_count`=0. A following 1-beat frame then completes with `frame_count`=1.
- Preload `frame_count` to 16'hFFFF via 65535 single-beat frames (or force) → the next frame makes it 0.
